// File: rtl/rsa_mod_prep.sv
// Moves an operand into the Montgomery domain: o_result = (i_a * 2^SHIFT) mod i_n.
// Works by iterative modular doubling, one bit per clock, with a start/finish handshake.
module rsa_mod_prep #(
    parameter int W     = 256,
    parameter int SHIFT = 256,
    parameter int CW    = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_n,
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_result,
    output logic         o_finish,
    output logic         o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_LOOP, S_DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(SHIFT - 1);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   t_q;
    logic [W-1:0]   n_q;
    logic [W-1:0]   result_q;
    logic           finish_q;
    logic           busy_q;

    logic           dbl_ge;
    logic [W-1:0]   step_d;
    logic [W-1:0]   pre_d;

    // The compare needs W+1 bits, but the subtract can wrap at W bits because
    // its true result is below n_q and so fits.
    assign dbl_ge = {t_q, 1'b0} >= {1'b0, n_q};
    assign step_d = dbl_ge ? ((t_q << 1) - n_q) : (t_q << 1);
    assign pre_d  = (t_q >= n_q) ? (t_q - n_q) : t_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            t_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        t_q     <= i_a;
                        n_q     <= i_n;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Operand may be up to 2n-1; one subtract restores t < n.
                    t_q     <= pre_d;
                    cnt_q   <= '0;
                    state_q <= S_LOOP;
                end
                S_LOOP: begin
                    t_q   <= step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q <= step_d;
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_result = result_q;
    assign o_finish = finish_q;
    assign o_busy   = busy_q;

endmodule
